n64_ctrl_sniffer: RTL and testbench
===================================

// Module: n64_ctrl_sniffer
// PURPOSE
// Passive sniffer on the N64 controller data line. Decodes console command 0x01 (poll) and the
// 32-bit controller reply, hands the word to the CPU domain via a new/ack toggle handshake and,
// when enabled, drives a console reset pulse on the in-game-reset button combo.
// Sits between the controller connector and the controller/CPU block; pad tri-stating is done at top.
// PARAMETERS
// TICK_DIV     12          N64_CLK_i cycles per sample tick (~4 MHz tick from ~48.7 MHz)
// IGR_PATTERN  16'h0C0C    captured word[15:0] that requests reset (Z,St,L,R pressed)
// RST_CNT_W    20          width of reset-pulse counter (pulse = 2^RST_CNT_W-1 ticks, ~260 ms)
// PORTS
// N64_CLK_i        in   1   clock
// CTRL_nRST        in   1   reset, asynchronous, active-low
// CTRL_i           in   1   controller data line (asynchronous, idle high)
// use_igr_i        in   1   IGR enable, async level (2-flop synchronised inside)
// data_tack_i      in   1   ack toggle from CPU domain (2-flop synchronised inside)
// ctrl_data_o      out  32  last captured controller word, bit0 = first received bit (A)
// new_ctrl_data_o  out  1   1 = unacknowledged word in ctrl_data_o
// drv_rst_o        out  1   1 = pull N64 reset low
// BEHAVIOUR
// Interface: reset CTRL_nRST, asynchronous, active-low; clock N64_CLK_i.
// - Reset values: all outputs 0; state WAIT; wait_cnt 0; hist 3'b111; shift reg/bit cnt 0; prescaler 0.
// - Prescaler 0..TICK_DIV-1, tick=1 when at TICK_DIV-1; all logic below except synchronisers
//   and handshake clear advances only on tick.
// - hist <= {hist[1:0],CTRL_i}; negedge = hist[2]&~hist[1]; posedge = ~hist[2]&hist[1].
// - wait_cnt (8b): cleared on either edge, else +1 saturating at 255; at 255 with no edge
//   state forced to WAIT (overrides FSM transition).
// - low_cnt (8b): on posedge in N64_RD/CTRL_RD, low_cnt <= wait_cnt (low duration).
// - bit value at a negedge = (low_cnt < wait_cnt), i.e. high phase longer than low phase -> '1'.
// FSM (2b: WAIT=0, N64_RD=1, CTRL_RD=2, 3 -> WAIT):
// - WAIT: wait_cnt==255 & negedge -> N64_RD; clear shift reg and bit cnt.
// - N64_RD: negedges 1..8 shift bit into cmd[7] (cmd <= {bit,cmd[7:1]}), bit cnt +1.
//   Next negedge (bit cnt==8): cmd==8'h80 (0x01 MSB-first) -> CTRL_RD, clear shift/cnt; else WAIT.
// - CTRL_RD: each negedge sr <= {bit,sr[31:1]}, cnt+1; on negedge with cnt==31 capture
//   {bit,sr[31:1]} into ctrl_data_o, set new_ctrl_data_o, -> WAIT.
// - Capture only on completed 32 bits; timeout mid-frame discards partial word, ctrl_data_o unchanged.
// Handshake:
// - data_tack_i synchronised by 2 flops, then 2-flop history; any change (toggle) clears
//   new_ctrl_data_o. Capture and clear in same cycle: capture wins (flag stays 1).
// - ctrl_data_o valid in the cycle new_ctrl_data_o rises; stable until next capture.
// IGR reset:
// - On a capture with synced use_igr=1 and word[15:0]==IGR_PATTERN: rst_cnt <= all ones,
//   drv_rst_o <= 1 next cycle. Each further matching capture retriggers (restarts count).
// - rst_cnt decrements per tick while nonzero; drv_rst_o <= 0 when rst_cnt==0.
// - CTRL_nRST assertion mid-pulse ends pulse immediately (drv_rst_o 0).
// TESTING
// T1 reset: assert CTRL_nRST=0 mid-frame -> all outputs 0, FSM WAIT, hist 111.
// T2 idle 70us high, send cmd 0x01 (0:3us low/1us high, 1:1us low/3us high) + stop, reply
//    32'h0000_0001 LSB-first order bits -> ctrl_data_o=32'h00000001, new_ctrl_data_o=1.
// T3 send cmd 0x00 then reply -> no capture, new flag stays 0, ctrl_data_o unchanged.
// T4 toggle data_tack_i once -> new_ctrl_data_o clears within 4 clocks; toggle coincident
//    with next capture -> flag stays 1.
// T5 reply truncated after 20 bits, line held high -> timeout to WAIT, no capture; next full frame captured.
// T6 use_igr_i=1, reply word[15:0]=16'h0C0C -> drv_rst_o=1 for 2^20-1 ticks then 0; use_igr_i=0 -> no pulse.

Source files
------------

// File: rtl/n64_ctrl_sniffer.sv
// n64_ctrl_sniffer
// Passive decoder for the N64 controller data line. Recognises the console poll command
// (0x01) and captures the 32-bit controller reply that follows it. Each captured word is
// handed to the CPU domain with a new/ack toggle handshake. Optionally, it raises a console
// reset pulse when the in-game-reset button combination is seen.
// Line timing: a bit is a low phase followed by a high phase. The bit is '1' when the high
// phase is longer than the low phase. Each bit is resolved at the falling edge that ends it.

module n64_ctrl_sniffer #(
    parameter int          TICK_DIV    = 12,
    parameter logic [15:0] IGR_PATTERN = 16'h0C0C,
    parameter int          RST_CNT_W   = 20
) (
    input  logic        N64_CLK_i,
    input  logic        CTRL_nRST,
    input  logic        CTRL_i,
    input  logic        use_igr_i,
    input  logic        data_tack_i,
    output logic [31:0] ctrl_data_o,
    output logic        new_ctrl_data_o,
    output logic        drv_rst_o
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam int                 N_SYNC     = 2;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_N64_RD  = 2'd1,
        ST_CTRL_RD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_reg;
    logic               tick;

    assign tick = (presc_reg == PRESC_LAST);

    // Free-running divider that produces one sample tick every TICK_DIV clocks
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the slow asynchronous level inputs
    // bit 0: ack toggle from the CPU side, bit 1: IGR enable
    // ------------------------------------------------------------------
    logic [N_SYNC-1:0] sync_in;
    logic [N_SYNC-1:0] sync_out;

    assign sync_in = {use_igr_i, data_tack_i};

    generate
        for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;

            // Plain double-register chain; runs every clock, not on the tick
            always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
                if (!CTRL_nRST) begin
                    meta_reg <= 1'b0;
                    out_reg  <= 1'b0;
                end else begin
                    meta_reg <= sync_in[gi];
                    out_reg  <= meta_reg;
                end
            end

            assign sync_out[gi] = out_reg;
        end
    endgenerate

    logic tack_sync;
    logic igr_en;

    assign tack_sync = sync_out[0];
    assign igr_en    = sync_out[1];

    // ------------------------------------------------------------------
    // Line history, edge detection and phase timing
    // ------------------------------------------------------------------
    logic [2:0] hist_reg;
    logic [7:0] wait_cnt_reg;
    logic [7:0] low_cnt_reg;
    logic       neg_edge;
    logic       pos_edge;
    logic       any_edge;
    logic       bit_val;
    logic       line_idle;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] sr_reg;
    logic [31:0] sr_next;
    logic [5:0]  bit_cnt_reg;
    logic [5:0]  bit_cnt_next;
    logic        capture;

    assign neg_edge  = hist_reg[2] & ~hist_reg[1];
    assign pos_edge  = ~hist_reg[2] & hist_reg[1];
    assign any_edge  = neg_edge | pos_edge;
    // At a falling edge wait_cnt holds the high-phase length and low_cnt the low-phase length
    assign bit_val   = (low_cnt_reg < wait_cnt_reg);
    assign line_idle = (wait_cnt_reg == 8'hFF);

    // Sample the line on each tick and measure how long it has been since the last edge
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            hist_reg     <= 3'b111;
            wait_cnt_reg <= 8'd0;
            low_cnt_reg  <= 8'd0;
        end else if (tick) begin
            hist_reg <= {hist_reg[1:0], CTRL_i};
            if (any_edge) begin
                wait_cnt_reg <= 8'd0;
            end else if (!line_idle) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if (pos_edge && (state_reg == ST_N64_RD || state_reg == ST_CTRL_RD)) begin
                low_cnt_reg <= wait_cnt_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: idle -> console command -> controller reply
    // ------------------------------------------------------------------

    // FSM state, shift register and bit counter registers
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state_reg   <= ST_WAIT;
            sr_reg      <= 32'd0;
            bit_cnt_reg <= 6'd0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Next-state decode; a frame only starts from a long idle-high period, and an idle
    // timeout always returns to WAIT, which drops any partially received word
    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        bit_cnt_next = bit_cnt_reg;
        capture      = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_WAIT: begin
                    if (line_idle && neg_edge) begin
                        state_next   = ST_N64_RD;
                        sr_next      = 32'd0;
                        bit_cnt_next = 6'd0;
                    end
                end
                ST_N64_RD: begin
                    if (neg_edge) begin
                        if (bit_cnt_reg == 6'd8) begin
                            // Command bits arrive MSB first, so 0x01 reads back as 0x80
                            if (sr_reg[31:24] == 8'h80) begin
                                state_next   = ST_CTRL_RD;
                                sr_next      = 32'd0;
                                bit_cnt_next = 6'd0;
                            end else begin
                                state_next = ST_WAIT;
                            end
                        end else begin
                            sr_next      = {bit_val, sr_reg[31:1]};
                            bit_cnt_next = bit_cnt_reg + 6'd1;
                        end
                    end
                end
                ST_CTRL_RD: begin
                    if (neg_edge) begin
                        sr_next = {bit_val, sr_reg[31:1]};
                        if (bit_cnt_reg == 6'd31) begin
                            capture    = 1'b1;
                            state_next = ST_WAIT;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_WAIT;
                end
            endcase

            if (line_idle && !any_edge) begin
                state_next = ST_WAIT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word hand-off to the CPU domain
    // ------------------------------------------------------------------
    logic [1:0] tack_hist_reg;
    logic       tack_toggle;

    assign tack_toggle = tack_hist_reg[1] ^ tack_hist_reg[0];

    // Latch the completed word and manage the new flag; a capture beats a same-cycle ack
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            tack_hist_reg   <= 2'b00;
            ctrl_data_o     <= 32'd0;
            new_ctrl_data_o <= 1'b0;
        end else begin
            tack_hist_reg <= {tack_hist_reg[0], tack_sync};
            if (capture) begin
                ctrl_data_o     <= sr_next;
                new_ctrl_data_o <= 1'b1;
            end else if (tack_toggle) begin
                new_ctrl_data_o <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-game reset pulse
    // ------------------------------------------------------------------
    logic [RST_CNT_W-1:0] rst_cnt_reg;
    logic                 igr_hit;

    assign igr_hit = capture && igr_en && (sr_next[15:0] == IGR_PATTERN);

    // Load the pulse counter on a matching capture (retriggers), then count it down
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            rst_cnt_reg <= '0;
            drv_rst_o   <= 1'b0;
        end else if (tick) begin
            if (igr_hit) begin
                rst_cnt_reg <= '1;
                drv_rst_o   <= 1'b1;
            end else if (rst_cnt_reg != '0) begin
                rst_cnt_reg <= rst_cnt_reg - RST_CNT_W'(1);
                drv_rst_o   <= (rst_cnt_reg != RST_CNT_W'(1));
            end else begin
                drv_rst_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_n64_ctrl_sniffer.sv
// Directed bench for n64_ctrl_sniffer. It drives N64 line frames, with timing measured in
// sample ticks. Expected captured words go into a scoreboard queue when a frame is sent and
// are popped when the word should appear at the outputs.
// The DUT runs with a small prescaler and a short reset-pulse counter so the run stays short.
// All line changes happen on falling clock edges that sit just after a tick edge. This keeps
// the DUT's sample points predictable.

module tb_n64_ctrl_sniffer;

    localparam int TD = 4;   // clocks per sample tick
    localparam int RW = 6;   // reset pulse = 2^RW-1 = 63 ticks

    logic        clk     = 1'b0;
    logic        nrst    = 1'b0;
    logic        ctrl    = 1'b1;
    logic        use_igr = 1'b0;
    logic        tack    = 1'b0;
    logic [31:0] data;
    logic        new_flag;
    logic        drv;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_word = 32'd0;
    logic        exp_new   = 1'b0;

    always #5 clk = ~clk;

    n64_ctrl_sniffer #(
        .TICK_DIV   (TD),
        .IGR_PATTERN(16'h0C0C),
        .RST_CNT_W  (RW)
    ) dut (
        .N64_CLK_i      (clk),
        .CTRL_nRST      (nrst),
        .CTRL_i         (ctrl),
        .use_igr_i      (use_igr),
        .data_tack_i    (tack),
        .ctrl_data_o    (data),
        .new_ctrl_data_o(new_flag),
        .drv_rst_o      (drv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TD) @(negedge clk);
    endtask

    task automatic drive(input logic lvl, input int ticks);
        ctrl = lvl;
        wait_ticks(ticks);
    endtask

    // '0' = 3 us low / 1 us high, '1' = 1 us low / 3 us high (4 ticks per us)
    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b0, 4);
            drive(1'b1, 12);
        end else begin
            drive(1'b0, 12);
            drive(1'b1, 4);
        end
    endtask

    // Idle, command MSB first, console stop bit, reply bit0 first, controller stop bit.
    // With tack_at_cap set, the ack toggle is timed so that the synchronised clear lands in
    // the capture cycle: the capture occurs 3 ticks after the stop-bit fall, and the ack
    // pipeline adds 4 clocks.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] word,
                              input int nbits, input bit tack_at_cap);
        if (cmd == 8'h01 && nbits == 32) exp_q.push_back(word);
        drive(1'b1, 300);
        for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
        drive(1'b0, 4);
        drive(1'b1, 8);
        for (int i = 0; i < nbits; i++) send_bit(word[i]);
        if (nbits == 32) begin
            ctrl = 1'b0;
            if (tack_at_cap) begin
                repeat (8) @(negedge clk);
                tack = ~tack;
                repeat (4 * TD - 8) @(negedge clk);
            end else begin
                wait_ticks(4);
            end
            ctrl = 1'b1;
        end
    endtask

    task automatic check_capture(input string tag);
        logic [31:0] w;
        w = exp_q.pop_front();
        chk({tag, "_data"}, data, w);
        chk({tag, "_new"}, 32'(new_flag), 32'd1);
        last_word = w;
        exp_new   = 1'b1;
    endtask

    task automatic check_no_capture(input string tag);
        chk({tag, "_data"}, data, last_word);
        chk({tag, "_new"}, 32'(new_flag), 32'(exp_new));
    endtask

    task automatic ack();
        tack = ~tack;
        repeat (TD) @(negedge clk);
        exp_new = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", data, 32'd0);
        chk("rst_new", 32'(new_flag), 32'd0);
        chk("rst_drv", 32'(drv), 32'd0);
        nrst = 1'b1;

        // T1: reset in the middle of a command
        drive(1'b1, 300);
        send_bit(1'b0);
        send_bit(1'b0);
        drive(1'b0, 6);
        nrst = 1'b0;
        #1;
        chk("t1_data", data, 32'd0);
        chk("t1_new", 32'(new_flag), 32'd0);
        chk("t1_drv", 32'(drv), 32'd0);
        @(negedge clk);
        ctrl = 1'b1;
        nrst = 1'b1;

        // T2: poll + reply
        send_frame(8'h01, 32'h0000_0001, 32, 1'b0);
        check_capture("t2");

        // T3: non-poll command is ignored
        send_frame(8'h00, 32'hFFFF_0000, 32, 1'b0);
        check_no_capture("t3");

        // T4: ack clears the flag; ack coincident with a capture leaves it set
        ack();
        chk("t4_ack_new", 32'(new_flag), 32'd0);
        send_frame(8'h01, 32'hDEAD_BEEF, 32, 1'b1);
        check_capture("t4_coinc");

        // T5: truncated reply times out without capture, next frame is captured
        ack();
        chk("t5_ack_new", 32'(new_flag), 32'd0);
        send_frame(8'h01, 32'h1357_9BDF, 20, 1'b0);
        wait_ticks(270);
        check_no_capture("t5_trunc");
        send_frame(8'h01, 32'h2468_ACE0, 32, 1'b0);
        check_capture("t5_full");

        // T6: IGR pulse length, then no pulse with IGR disabled
        use_igr = 1'b1;
        send_frame(8'h01, 32'hA5A5_0C0C, 32, 1'b0);
        check_capture("t6_match");
        chk("t6_drv_start", 32'(drv), 32'd1);
        wait_ticks(61);
        chk("t6_drv_late", 32'(drv), 32'd1);
        wait_ticks(2);
        chk("t6_drv_end", 32'(drv), 32'd0);
        use_igr = 1'b0;
        send_frame(8'h01, 32'h5A5A_0C0C, 32, 1'b0);
        check_capture("t6_noigr");
        chk("t6_noigr_drv", 32'(drv), 32'd0);

        // Reset in the middle of a reset pulse ends it at once
        use_igr = 1'b1;
        send_frame(8'h01, 32'h0000_0C0C, 32, 1'b0);
        check_capture("t6_pulse");
        wait_ticks(10);
        chk("t6_pulse_drv", 32'(drv), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rst2_drv", 32'(drv), 32'd0);
        chk("rst2_new", 32'(new_flag), 32'd0);
        chk("rst2_data", data, 32'd0);
        last_word = 32'd0;
        exp_new   = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        // Recovery after reset
        send_frame(8'h01, 32'h8765_4321, 32, 1'b0);
        check_capture("recover");
        chk("recover_drv", 32'(drv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
